// File: rtl/ir_fetch_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue.
// Holds the NOP encoding, the default datapath width and a ceil-log2 helper.
package ir_fetch_queue_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [31:0] IR_NOP = 32'h0000_0000;

  // Ceiling log2 that elaborates as a constant function.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ir_fetch_queue_ptr.sv
// Wrap-bit pointer for the instruction queue: the MSB toggles each lap so that
// full and empty can be told apart when the index bits match.
module ir_fetch_queue_ptr
  import ir_fetch_queue_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  // clr is the synchronous flush and wins over inc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
  end

endmodule

// File: rtl/ir_fetch_queue.sv
// Instruction queue between fetch and DECODE: circular buffer of {pc, ir} pairs.
// Define IR_FETCH_QUEUE_BYPASS_EN to let an empty queue forward a push in the same cycle.
module ir_fetch_queue
  import ir_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = DEFAULT_XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [XLEN-1:0]       push_pc,
  input  logic [XLEN-1:0]       push_ir,
  output logic                  push_ready,
  output logic                  pop_valid,
  output logic [XLEN-1:0]       pop_pc,
  output logic [XLEN-1:0]       pop_ir,
  input  logic                  pop_ready,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            empty;
  logic            full;
  logic            bypass_hit;
  logic            push_acc;
  logic            pop_acc;
  logic            wr_inc;
  logic            rd_inc;
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [XLEN-1:0] mem_ir [DEPTH];

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count  = wr_ptr - rd_ptr;

  assign push_ready = !full;

`ifdef IR_FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = empty && push_valid && !flush;
`else
  assign bypass_hit = 1'b0;
`endif

  assign pop_valid = !empty || bypass_hit;
  assign push_acc  = push_valid && push_ready && !flush;
  assign pop_acc   = pop_valid && pop_ready && !flush;

  // A bypassed entry that DECODE takes immediately never touches storage.
  assign wr_inc = push_acc && !(bypass_hit && pop_ready);
  assign rd_inc = pop_acc && !empty;

  always_comb begin
    pop_pc = '0;
    pop_ir = XLEN'(IR_NOP);
    if (bypass_hit) begin
      pop_pc = push_pc;
      pop_ir = push_ir;
    end else if (!empty) begin
      pop_pc = mem_pc[rd_idx];
      pop_ir = mem_ir[rd_idx];
    end
  end

  // Storage is deliberately not reset; reads are gated by !empty.
  always_ff @(posedge clk) begin
    if (wr_inc) begin
      mem_pc[wr_idx] <= push_pc;
      mem_ir[wr_idx] <= push_ir;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          overflow <= 1'b0;
    else if (flush)                     overflow <= 1'b0;
    else if (push_valid && !push_ready) overflow <= 1'b1;
  end

  ir_fetch_queue_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_inc),
    .clr   (flush),
    .ptr   (wr_ptr)
  );

  ir_fetch_queue_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_inc),
    .clr   (flush),
    .ptr   (rd_ptr)
  );

endmodule
